// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_forward_sel.sv
// rtl/hazard_forward_sel.sv - per-operand forwarding select; Memory beats Writeback
module hazard_forward_sel
    import pipeline_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic [ADDRESS_WIDTH-1:0] RsE,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    output fwd_sel_t                 Forward
);

    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == RsE))
            Forward = FWD_MEM;
        else if (RegWriteW && (RdW != '0) && (RdW == RsE))
            Forward = FWD_WB;
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/forward control with bounded memory-wait freeze
// Optional performance counters enabled by HAZARD_PERF_EN.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic [ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [ADDRESS_WIDTH-1:0] RdE,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcE,
    input  logic                     PCSrcE,
    input  logic                     MemReqM,
    input  logic                     MemReadyM,
    output logic [1:0]               ForwardAE,
    output logic [1:0]               ForwardBE,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     StallM,
    output logic                     StallW,
    output logic                     FlushD,
    output logic                     FlushE,
`ifdef HAZARD_PERF_EN
    output logic [CNT_WIDTH-1:0]     LoadStallCnt,
    output logic [CNT_WIDTH-1:0]     FlushCnt,
    output logic [CNT_WIDTH-1:0]     MemWaitCnt,
`endif
    output logic                     MemErr
);

    localparam int              TW          = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMEOUT_VAL = TW'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || CNT_WIDTH < 1) begin : g_param_check
        $error("hazard_controller: MEM_TIMEOUT and CNT_WIDTH must be >= 1");
    end

    fwd_sel_t   fwd_a, fwd_b;
    mem_state_t state_q, state_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic       err_d;
    logic       freeze;
    logic       lw_stall;

    hazard_forward_sel #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_a (
        .RsE(Rs1E), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Forward(fwd_a)
    );

    hazard_forward_sel #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_b (
        .RsE(Rs2E), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Forward(fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            MemErr     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            MemErr     <= err_d;
        end
    end

    // Timeout exit releases the freeze in the same cycle the counter hits the limit.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = MemErr;
        freeze     = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    freeze     = 1'b1;
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                if (MemReadyM) begin
                    state_d = IDLE;
                end else if (wait_cnt_q < TIMEOUT_VAL) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall | PCSrcE;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            LoadStallCnt <= '0;
            FlushCnt     <= '0;
            MemWaitCnt   <= '0;
        end else begin
            if (!freeze && lw_stall) LoadStallCnt <= LoadStallCnt + 1'b1;
            if (!freeze && PCSrcE)   FlushCnt     <= FlushCnt + 1'b1;
            if (freeze)              MemWaitCnt   <= MemWaitCnt + 1'b1;
        end
    end
`endif

endmodule
